// File: rtl/tdm_mux8_arbiter_pkg.sv
// Shared constants for the 8:1 TDM combiner.
// Channel count, id width and output-register state codes.
package tdm_mux8_arbiter_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

endpackage

// File: rtl/tdm_mux8_arbiter_rr_pick8.sv
// Round-robin picker for 8 requesters.
// Rotates requests so ptr sits at bit 0, priority-encodes, un-rotates.
module tdm_mux8_arbiter_rr_pick8
  import tdm_mux8_arbiter_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  input  logic              en,
  output logic [NUM_CH-1:0] gnt,
  output logic [SEL_W-1:0]  gnt_id,
  output logic              any
);

  logic [2*NUM_CH-1:0] dbl;
  logic [NUM_CH-1:0]   rot;
  logic [SEL_W-1:0]    off;

  assign dbl = {req, req} >> ptr;
  assign rot = dbl[NUM_CH-1:0];

  // Lowest set bit of the rotated vector is the nearest request at or after ptr.
  always_comb begin
    off = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
  end

  assign any    = en & (|req);
  assign gnt_id = off + ptr;
  assign gnt    = any ? (NUM_CH'(1) << gnt_id) : '0;

endmodule

// File: rtl/tdm_mux8_arbiter.sv
// Sequential 8:1 combiner: round-robin grant into one registered
// output beat tagged with its source channel id.
module tdm_mux8_arbiter
  import tdm_mux8_arbiter_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
);

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [SEL_W-1:0]  ptr;
  logic [NUM_CH-1:0] gnt;
  logic [SEL_W-1:0]  gnt_id;
  logic              any;
  logic              load_ok;
  logic              pick_en;
  logic [WIDTH-1:0]  pick_data;

  assign out_valid = (state == FULL);
  assign load_ok   = !out_valid | out_ready;
  // No channel may be acknowledged while reset is asserted.
  assign pick_en   = load_ok & !rst;

  tdm_mux8_arbiter_rr_pick8 u_pick (
    .req    (in_valid),
    .ptr    (ptr),
    .en     (pick_en),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (any)
  );

  assign in_ready = gnt;

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_id == SEL_W'(i)) pick_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY:   state_nxt = any ? FULL : EMPTY;
      FULL:    if (out_ready) state_nxt = any ? FULL : EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      out_data <= '0;
      out_sel  <= '0;
      ptr      <= '0;
    end else begin
      state <= state_nxt;
      if (any) begin
        out_data <= pick_data;
        out_sel  <= gnt_id;
        ptr      <= gnt_id + SEL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tdm_mux8_arbiter.sv
// Scoreboard bench for tdm_mux8_arbiter: driver/model pushes
// expected beats, a monitor pops and compares them on handshake.
module tb_tdm_mux8_arbiter;

  localparam int W  = 4;
  localparam int NC = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NC-1:0]   in_valid;
  logic [NC*W-1:0] in_data;
  logic [NC-1:0]   in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [2:0]      out_sel;
  logic            out_ready;

  tdm_mux8_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sel;
    int data;
  } beat_t;

  beat_t q[$];
  int    m_ptr;
  int    last_sel;
  int    last_data;
  int    n_chk;
  int    n_fail;
  bit    done;

  task automatic check(input bit ok, input string name,
                       input int act, input int exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: output register must mirror the model's held beat.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!done) begin
        check(out_valid === (q.size() > 0), "out_valid",
              int'(out_valid), int'(q.size() > 0));
        if (q.size() > 0) begin
          check(int'(out_sel) == q[0].sel, "out_sel",
                int'(out_sel), q[0].sel);
          check(int'(out_data) == q[0].data, "out_data",
                int'(out_data), q[0].data);
          if (out_ready) void'(q.pop_front());
        end else begin
          check(int'(out_sel) == last_sel, "held_sel",
                int'(out_sel), last_sel);
          check(int'(out_data) == last_data, "held_data",
                int'(out_data), last_data);
        end
      end
    end
  end

  // One cycle: apply inputs, check in_ready against the model, advance model.
  task automatic step(input bit r, input logic [NC-1:0] v,
                      input logic [NC*W-1:0] d, input bit ordy);
    int g;
    logic [NC-1:0] exp_rdy;
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    #2;
    g = -1;
    if (!r && q.size() == 0) begin
      for (int k = 0; k < NC; k++) begin
        if (g < 0 && v[(m_ptr + k) % NC]) g = (m_ptr + k) % NC;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check(in_ready === exp_rdy, "in_ready", int'(in_ready), int'(exp_rdy));
    if (r) begin
      q.delete();
      m_ptr     = 0;
      last_sel  = 0;
      last_data = 0;
    end else if (g >= 0) begin
      beat_t b;
      b.sel     = g;
      b.data    = int'(d[g*W +: W]);
      q.push_back(b);
      m_ptr     = (g + 1) % NC;
      last_sel  = b.sel;
      last_data = b.data;
    end
  endtask

  function automatic logic [NC*W-1:0] rnd_data();
    logic [NC*W-1:0] d;
    d = {$urandom(), $urandom()};
    return d;
  endfunction

  initial begin
    n_chk = 0;
    n_fail = 0;
    done = 1'b0;
    m_ptr = 0;
    last_sel = 0;
    last_data = 0;
    rst = 1'b1;
    in_valid = '0;
    in_data = '0;
    out_ready = 1'b0;

    step(1, '0, '0, 0);
    step(1, 8'hFF, rnd_data(), 1);

    // Single channel 5 with data 1.
    step(0, 8'b0010_0000, {8{4'h1}}, 1);
    step(0, '0, '0, 1);
    step(0, '0, '0, 1);

    // All valid from reset: 0..7 then wrap to 0.
    step(1, '0, '0, 1);
    for (int i = 0; i < 9; i++) step(0, 8'hFF, rnd_data(), 1);

    // Reach sel=2 held, then stall three cycles.
    step(1, '0, '0, 1);
    step(0, 8'b0000_0100, rnd_data(), 1);
    for (int i = 0; i < 3; i++) step(0, 8'hFF, rnd_data(), 0);
    step(0, '0, '0, 1);

    // Grant 6 then channels 7 and 2.
    step(0, 8'b0100_0000, rnd_data(), 1);
    for (int i = 0; i < 3; i++) step(0, 8'b1000_0100, rnd_data(), 1);
    step(0, '0, '0, 1);

    // Reset while holding sel=4.
    step(0, 8'b0001_0000, rnd_data(), 0);
    step(0, '0, '0, 0);
    step(1, 8'b0000_1001, rnd_data(), 0);
    for (int i = 0; i < 2; i++) step(0, 8'b0000_1001, rnd_data(), 1);

    // Drain with no new requests.
    step(0, '0, '0, 1);
    step(0, '0, '0, 1);

    // Randomised traffic with varying density and back-pressure.
    for (int i = 0; i < 600; i++) begin
      logic [NC-1:0] v;
      int dens;
      dens = (i / 100) % 3;
      v = NC'($urandom());
      if (dens == 0) v = v & NC'($urandom()) & NC'($urandom());
      if (dens == 2) v = v | NC'($urandom());
      step(($urandom_range(0, 99) == 0), v, rnd_data(),
           ($urandom_range(0, 3) != 0));
    end

    @(negedge clk);
    #3;
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
